// File: rtl/vga_scan.sv
// vga_scan: VGA raster counters, draw-block coordinate source and sync/colour alignment pipeline.
// Define VGA_GRID_OVERLAY_EN to paint the 16x16 map grid white during active video.
module vga_scan #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int MAP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] x,
    output logic [10:0] y,
    input  logic [11:0] color_in,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LAST    = MAP_LATENCY - 1;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_ON      = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_OFF     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_ON      = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_OFF     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] NULL_COORD = 11'h400;

    logic [10:0]            h_cnt;
    logic [10:0]            v_cnt;
    logic                   active_now;
    logic                   hs_now;
    logic                   vs_now;
    logic [MAP_LATENCY-1:0] active_d;
    logic [MAP_LATENCY-1:0] hs_d;
    logic [MAP_LATENCY-1:0] vs_d;
    logic [11:0]            pix_color;

    assign active_now = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_now     = !((h_cnt >= HS_ON) && (h_cnt < HS_OFF));
    assign vs_now     = !((v_cnt >= VS_ON) && (v_cnt < VS_OFF));

    // Combinational so the pulse lands on the very pix_en step that consumes raster (0,0).
    assign frame_start = pix_en && !rst && (h_cnt == 11'd0) && (v_cnt == 11'd0);

`ifdef VGA_GRID_OVERLAY_EN
    logic [MAP_LATENCY-1:0][3:0] gx_d;
    logic [MAP_LATENCY-1:0][3:0] gy_d;

    assign pix_color = (gx_d[LAST] == 4'd0 || gy_d[LAST] == 4'd0) ? 12'hFFF : color_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_d <= '0;
            gy_d <= '0;
        end else if (pix_en) begin
            gx_d[0] <= h_cnt[3:0];
            gy_d[0] <= v_cnt[3:0];
            for (int i = 1; i < MAP_LATENCY; i++) begin
                gx_d[i] <= gx_d[i-1];
                gy_d[i] <= gy_d[i-1];
            end
        end
    end
`else
    assign pix_color = color_in;
`endif

    always_ff @(posedge clk) begin
        // NOTE: the alignment stages are reset too; otherwise sync pins glitch on the first line.
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            x        <= NULL_COORD;
            y        <= NULL_COORD;
            active_d <= '0;
            hs_d     <= '1;
            vs_d     <= '1;
            r        <= '0;
            g        <= '0;
            b        <= '0;
            hs       <= 1'b1;
            vs       <= 1'b1;
        end else if (pix_en) begin
            // NOTE: non-blocking throughout, so every stage shifts on the old value of its neighbour.
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end

            x <= active_now ? h_cnt : NULL_COORD;
            y <= active_now ? v_cnt : NULL_COORD;

            active_d[0] <= active_now;
            hs_d[0]     <= hs_now;
            vs_d[0]     <= vs_now;
            for (int i = 1; i < MAP_LATENCY; i++) begin
                active_d[i] <= active_d[i-1];
                hs_d[i]     <= hs_d[i-1];
                vs_d[i]     <= vs_d[i-1];
            end

            // Stage LAST lines up with the colour the draw blocks return for that pixel.
            hs <= hs_d[LAST];
            vs <= vs_d[LAST];
            if (active_d[LAST]) begin
                r <= pix_color[11:8];
                g <= pix_color[7:4];
                b <= pix_color[3:0];
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: directed checks of vga_scan at full 640x480 timing plus a small-raster
// instance (latency 2) that makes whole frames and the grid overlay reachable quickly.
module tb_vga_scan;
    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        pix_en2;
    logic [11:0] color_in;
    logic [11:0] color2;
    logic [10:0] x, y, x2, y2;
    logic [3:0]  r, g, b, r2, g2, b2;
    logic        hs, vs, fs, hs2, vs2, fs2;

    int total = 0;
    int bad   = 0;
    int hs_low, hs_first, fs_cnt, vs_low, vs_first;
    int q, hq, vq, h, v;
    logic fs_s;
    logic [11:0] col, e_rgb;
    logic e_hs, e_vs;

    always #5 clk = ~clk;

    vga_scan dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .color_in(color_in),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .frame_start(fs)
    );

    // 27 x 38 raster: active 20x34, hsync at h 22..24, vsync at v 35..36.
    vga_scan #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(34), .V_FP(1), .V_SYNC(2), .V_BP(1), .MAP_LATENCY(2)
    ) dut2 (
        .clk(clk), .rst(rst), .pix_en(pix_en2), .x(x2), .y(y2), .color_in(color2),
        .r(r2), .g(g2), .b(b2), .hs(hs2), .vs(vs2), .frame_start(fs2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] rgb_exp(input int ph, input int pv, input int ha,
                                            input int va, input logic [11:0] c);
        if (ph >= ha || pv >= va) return 12'h000;
`ifdef VGA_GRID_OVERLAY_EN
        if (ph % 16 == 0 || pv % 16 == 0) return 12'hFFF;
`endif
        return c;
    endfunction

    // One pix_en strobe every 4 clk; frame_start sampled while the strobe is high.
    task automatic step_main(input logic [11:0] c, output logic fs_o);
        @(negedge clk);
        color_in = c;
        pix_en   = 1'b1;
        #1 fs_o  = fs;
        @(negedge clk);
        pix_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic step_small(output logic fs_o);
        @(negedge clk);
        pix_en2 = 1'b1;
        #1 fs_o = fs2;
        @(negedge clk);
        pix_en2 = 1'b0;
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        pix_en   = 1'b0;
        pix_en2  = 1'b0;
        color_in = 12'hABC;
        color2   = 12'h333;
        repeat (3) @(negedge clk);
        #1;
        check("rst_x", 32'(x), 32'h400);
        check("rst_y", 32'(y), 32'h400);
        check("rst_rgb", 32'({r, g, b}), 32'h0);
        check("rst_hs", 32'(hs), 32'h1);
        check("rst_vs", 32'(vs), 32'h1);
        check("rst_x2", 32'(x2), 32'h400);
        pix_en = 1'b1;
        #1 check("rst_fs", 32'(fs), 32'h0);
        @(negedge clk);
        pix_en = 1'b0;
        rst    = 1'b0;

        // Line 0: colour ABC through the active region, FFF once blanking is being sampled.
        hs_low   = 0;
        hs_first = -1;
        for (int j = 0; j < 800; j++) begin
            col = (j <= 640) ? 12'hABC : 12'hFFF;
            step_main(col, fs_s);
            check($sformatf("fs@%0d", j), 32'(fs_s), 32'(j == 0));
            check($sformatf("x@%0d", j), 32'(x), (j < 640) ? 32'(j) : 32'h400);
            check($sformatf("y@%0d", j), 32'(y), (j < 640) ? 32'h0 : 32'h400);
            q     = j - 1;
            e_rgb = (q < 0) ? 12'h000 : rgb_exp(q, 0, 640, 480, col);
            e_hs  = (q < 0) ? 1'b1 : !(q >= 656 && q < 752);
            check($sformatf("rgb@%0d", j), 32'({r, g, b}), 32'(e_rgb));
            check($sformatf("hs@%0d", j), 32'(hs), 32'(e_hs));
            check($sformatf("vs@%0d", j), 32'(vs), 32'h1);
            if (!hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = j;
            end
        end
        check("hs_low_len", 32'(hs_low), 32'd96);
        check("hs_low_first", 32'(hs_first), 32'd657);

        // Line wrap: 800 steps per line.
        step_main(12'hABC, fs_s);
        check("wrap_x", 32'(x), 32'h0);
        check("wrap_y", 32'(y), 32'h1);
        check("wrap_fs", 32'(fs_s), 32'h0);
        check("wrap_rgb", 32'({r, g, b}), 32'h0);
        for (int j = 801; j <= 850; j++) step_main(12'hABC, fs_s);

        // Freeze for 100 clk mid-line with a different colour on the input.
        @(negedge clk);
        color_in = 12'h555;
        repeat (100) @(negedge clk);
        #1;
        check("frz_x", 32'(x), 32'd50);
        check("frz_y", 32'(y), 32'd1);
        check("frz_rgb", 32'({r, g, b}), 32'(rgb_exp(49, 1, 640, 480, 12'hABC)));
        check("frz_hs", 32'(hs), 32'h1);
        check("frz_vs", 32'(vs), 32'h1);
        step_main(12'hABC, fs_s);
        check("resume_x", 32'(x), 32'd51);
        check("resume_rgb", 32'({r, g, b}), 32'(rgb_exp(50, 1, 640, 480, 12'hABC)));
        for (int j = 852; j <= 1099; j++) step_main(12'hABC, fs_s);
        check("pre_rst_x", 32'(x), 32'd299);

        // Mid-line reset with h_cnt at 300.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_x", 32'(x), 32'h400);
        check("mid_rst_y", 32'(y), 32'h400);
        check("mid_rst_rgb", 32'({r, g, b}), 32'h0);
        check("mid_rst_hs", 32'(hs), 32'h1);
        check("mid_rst_vs", 32'(vs), 32'h1);
        pix_en = 1'b1;
        #1 check("mid_rst_fs", 32'(fs), 32'h0);
        @(negedge clk);
        pix_en = 1'b0;
        rst    = 1'b0;
        step_main(12'hABC, fs_s);
        check("restart_fs", 32'(fs_s), 32'h1);
        check("restart_x", 32'(x), 32'h0);
        check("restart_y", 32'(y), 32'h0);
        check("restart_rgb", 32'({r, g, b}), 32'h0);

        // Small raster: one full frame (1026 steps) plus the first step of the next.
        fs_cnt   = 0;
        vs_low   = 0;
        vs_first = -1;
        for (int j = 0; j <= 1026; j++) begin
            step_small(fs_s);
            h = j % 27;
            v = (j / 27) % 38;
            q = j - 2;
            if (q < 0) begin
                e_rgb = 12'h000;
                e_hs  = 1'b1;
                e_vs  = 1'b1;
            end else begin
                hq    = q % 27;
                vq    = (q / 27) % 38;
                e_rgb = rgb_exp(hq, vq, 20, 34, 12'h333);
                e_hs  = !(hq >= 22 && hq < 25);
                e_vs  = !(vq >= 35 && vq < 37);
            end
            check($sformatf("s_fs@%0d", j), 32'(fs_s), 32'(j % 1026 == 0));
            check($sformatf("s_x@%0d", j), 32'(x2), (h < 20 && v < 34) ? 32'(h) : 32'h400);
            check($sformatf("s_y@%0d", j), 32'(y2), (h < 20 && v < 34) ? 32'(v) : 32'h400);
            check($sformatf("s_rgb@%0d", j), 32'({r2, g2, b2}), 32'(e_rgb));
            check($sformatf("s_hs@%0d", j), 32'(hs2), 32'(e_hs));
            check($sformatf("s_vs@%0d", j), 32'(vs2), 32'(e_vs));
            if (fs_s) fs_cnt++;
            if (j < 1026 && !vs2) begin
                vs_low++;
                if (vs_first < 0) vs_first = j;
            end
            if (j == 151) check("s_x16_y5", 32'({x2, y2}), {10'd0, 11'd16, 11'd5});
            if (j == 155) check("s_h20_null", 32'(x2), 32'h400);
            if (j == 918) check("s_v34_null", 32'(y2), 32'h400);
`ifdef VGA_GRID_OVERLAY_EN
            if (j == 153) check("grid_16_5", 32'({r2, g2, b2}), 32'hFFF);
            if (j == 154) check("grid_17_5", 32'({r2, g2, b2}), 32'h333);
            if (j == 883) check("grid_17_32", 32'({r2, g2, b2}), 32'hFFF);
`else
            if (j == 153) check("pix_16_5", 32'({r2, g2, b2}), 32'h333);
            if (j == 883) check("pix_17_32", 32'({r2, g2, b2}), 32'h333);
`endif
        end
        check("s_fs_count", 32'(fs_cnt), 32'd2);
        check("s_vs_low_len", 32'(vs_low), 32'd54);
        check("s_vs_low_first", 32'(vs_first), 32'd947);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_scan.md
Name: vga_scan

Overview:
- Display-side consumer of the map renderer interface: generates the pixel coordinate stream (x, y) that map/draw blocks decode, and captures their 12-bit color answer.
- Aligns the answer with VGA sync timing and drives RGB, hsync and vsync to the board connector.
- Sits at top level between the pixel-enable divider and the map/ball draw blocks.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- MAP_LATENCY, 1, pixel steps between x/y presented and color_in valid (1..4)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-step strobe; all counters and pipeline stages advance only when high
- x  out  11  column to draw blocks; bit 10 set outside active area
- y  out  11  row to draw blocks; bit 10 set outside active area
- color_in  in  12  {R[3:0],G[3:0],B[3:0]} from draw blocks
- r  out  4  VGA red
- g  out  4  VGA green
- b  out  4  VGA blue
- hs  out  1  hsync, active-low
- vs  out  1  vsync, active-low
- frame_start  out  1  one-clk pulse on the pix_en step where h_cnt=0, v_cnt=0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Counters:
  - h_cnt spans 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - v_cnt spans 0..V_TOTAL-1 (525).
  - Both are 11-bit and advance only on pix_en.
  - h_cnt wraps H_TOTAL-1 to 0. On that same step v_cnt increments; v_cnt wraps V_TOTAL-1 to 0.
- Reset values:
  - h_cnt=0, v_cnt=0.
  - x=11'h400, y=11'h400.
  - r=g=b=0, hs=1, vs=1, frame_start=0.
  - All delay stages are cleared to the blank/inactive state.
  - Reset mid-line takes effect on the next clk edge regardless of pix_en.
- Phase order within a line: active, then front porch, then sync, then back porch.
  - Raw hsync is low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Raw vsync uses the same rule with the V_ parameters.
- Coordinate output (registered):
  - When h_cnt<H_ACTIVE and v_cnt<V_ACTIVE: x=h_cnt, y=v_cnt, with bit 10 = 0.
  - Otherwise x=11'h400 and y=11'h400, so the draw blocks return their NULL color.
  - x and y hold their value between pix_en strobes.
- Alignment pipeline:
  - active, hsync and vsync pass through MAP_LATENCY pix_en-gated stages.
  - color_in is sampled on the pix_en step where the delayed active flag is valid.
  - r/g/b/hs/vs change only on pix_en steps, so the total latency from x/y to pins is MAP_LATENCY pixel steps.
- Blanking: while the delayed active flag is 0, r=g=b=0 regardless of color_in.
- pix_en spacing: strobes must be at least 2 clk apart, so the registered draw-block output settles before capture. pix_en held permanently high is legal only with draw blocks of zero internal latency. This is an integration requirement, not checked in RTL.
- frame_start: asserted for exactly one clk, coincident with the pix_en at h_cnt=0, v_cnt=0. It is not asserted out of reset until that step occurs.

Optional Feature:
- Macro: VGA_GRID_OVERLAY_EN.
- Defined:
  - During active video, when the delayed x[3:0]==0 or delayed y[3:0]==0, output r=g=b=4'hF (white) instead of color_in.
  - This overlays the 16x16 block grid used by the map for wall-placement debug.
  - The delayed x/y copies are added to the alignment pipeline.
- Undefined: no overlay logic and no delayed coordinate registers; behaviour exactly as above.

Test Plan:
- Reset then pix_en every 4th clk, color_in=12'hABC constant:
  - r=A, g=B, b=C from pixel step 1+MAP_LATENCY of line 0.
  - hs low for exactly 96 steps starting at step 656 (+latency).
  - 800 steps per line.
- Full frame count:
  - vs low for exactly 2 lines starting at line 490.
  - 525 lines per frame.
  - frame_start pulses once per 420000 pix_en steps.
- Coordinates:
  - At h_cnt=639, v_cnt=0, x=639 and y=0.
  - At h_cnt=640, x=11'h400.
  - At v_cnt=480, y=11'h400.
  - r/g/b=0 throughout blanking even with color_in=12'hFFF.
- pix_en held low for 100 clk mid-line: x, y, r/g/b, hs and vs remain frozen; resumption continues from the same h_cnt.
- rst asserted at h_cnt=300, v_cnt=200:
  - Next clk gives x=11'h400, hs=vs=1, rgb=0.
  - After release, the first pix_en restarts at h_cnt=0, v_cnt=0 with a frame_start pulse.
- VGA_GRID_OVERLAY_EN defined, color_in=12'h333: pixel x=16,y=5 outputs FFF; x=17,y=5 outputs 333; x=17,y=32 outputs FFF.
